// File: rtl/vga_scan_driver.sv
// VGA scan timing generator: pixel-rate divider, h/v scan counters, and
// registered sync/colour outputs that trail the published scan position by one pixel.
module vga_scan_driver #(
  parameter int CLK_DIV   = 4,
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] vga_data,
  output logic [9:0]  h_cnt,
  output logic [9:0]  v_cnt,
  output logic        valid,
  output logic        pclk_en,
  output logic        frame_tick,
  output logic        hsync,
  output logic        vsync,
  output logic [3:0]  vgaRed,
  output logic [3:0]  vgaGreen,
  output logic [3:0]  vgaBlue
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = $clog2(CLK_DIV);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FP + V_SYNC);

  logic [DIV_W-1:0] div_r;
  logic [9:0]       h_cnt_r;
  logic [9:0]       v_cnt_r;
  logic             hsync_r;
  logic             vsync_r;
  logic [11:0]      rgb_r;

  logic             pclk_en_s;
  logic             valid_s;
  logic             h_wrap_s;
  logic             frame_end_s;
  logic             hsync_low_s;
  logic             vsync_low_s;
  logic [9:0]       h_next_s;
  logic [9:0]       v_next_s;
  logic [11:0]      rgb_next_s;

  // Fetch-stage decode: pixel strobe, visibility, sync windows and next counter values.
  always_comb begin
    pclk_en_s   = (div_r == DIV_LAST);
    valid_s     = (h_cnt_r < H_VIS) && (v_cnt_r < V_VIS);
    h_wrap_s    = (h_cnt_r == H_LAST);
    frame_end_s = h_wrap_s && (v_cnt_r == V_LAST);
    hsync_low_s = (h_cnt_r >= HS_START) && (h_cnt_r < HS_END);
    vsync_low_s = (v_cnt_r >= VS_START) && (v_cnt_r < VS_END);
    h_next_s    = h_cnt_r;
    v_next_s    = v_cnt_r;
    rgb_next_s  = 12'h000;

    if (h_wrap_s) begin
      h_next_s = 10'd0;
      if (v_cnt_r == V_LAST) begin
        v_next_s = 10'd0;
      end else begin
        v_next_s = v_cnt_r + 10'd1;
      end
    end else begin
      h_next_s = h_cnt_r + 10'd1;
    end

    // Blanking forces black whatever the scene returns.
    if (valid_s) begin
      rgb_next_s = vga_data;
    end else begin
      rgb_next_s = 12'h000;
    end
  end

  // Divider, scan counters and pin registers; reset wins over the pixel strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_r   <= '0;
      h_cnt_r <= 10'd0;
      v_cnt_r <= 10'd0;
      hsync_r <= 1'b1;
      vsync_r <= 1'b1;
      rgb_r   <= 12'h000;
    end else begin
      div_r <= div_r + DIV_W'(1);
      if (pclk_en_s) begin
        h_cnt_r <= h_next_s;
        v_cnt_r <= v_next_s;
        hsync_r <= ~hsync_low_s;
        vsync_r <= ~vsync_low_s;
        rgb_r   <= rgb_next_s;
      end
    end
  end

  assign h_cnt      = h_cnt_r;
  assign v_cnt      = v_cnt_r;
  assign valid      = valid_s;
  assign pclk_en    = pclk_en_s;
  assign frame_tick = pclk_en_s && frame_end_s;
  assign hsync      = hsync_r;
  assign vsync      = vsync_r;
  assign vgaRed     = rgb_r[11:8];
  assign vgaGreen   = rgb_r[7:4];
  assign vgaBlue    = rgb_r[3:0];

endmodule

// File: tb/tb_vga_scan_driver.sv
// Scoreboard bench for vga_scan_driver on a shrunken raster (25x19 pixels, CLK_DIV 4)
// so that two whole frames fit in a short run.
module tb_vga_scan_driver;

  localparam int CLK_DIV = 4;
  localparam int HV = 16, HF = 2, HS = 4, HB = 3;
  localparam int VV = 12, VF = 2, VS = 2, VB = 3;
  localparam int HT = 25;   // 16+2+4+3
  localparam int VT = 19;   // 12+2+2+3
  localparam int FRAME_CLK = 1900;  // 25*19*4

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] vga_data = 12'h000;
  logic [9:0]  h_cnt, v_cnt;
  logic        valid, pclk_en, frame_tick, hsync, vsync;
  logic [3:0]  vgaRed, vgaGreen, vgaBlue;

  vga_scan_driver #(
    .CLK_DIV(CLK_DIV), .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .clk(clk), .rst(rst), .vga_data(vga_data),
    .h_cnt(h_cnt), .v_cnt(v_cnt), .valid(valid), .pclk_en(pclk_en),
    .frame_tick(frame_tick), .hsync(hsync), .vsync(vsync),
    .vgaRed(vgaRed), .vgaGreen(vgaGreen), .vgaBlue(vgaBlue)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          edge_n;
    int          h;
    int          v;
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
    logic        vl;
    logic        ft;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  int   m_div = 0, m_h = 0, m_v = 0;
  logic meas_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  function automatic logic [11:0] pat(input int h, input int v);
    if (h == 0 && v == 0) return 12'hABC;
    else if (h == 3 && v == 2) return 12'h123;
    else return 12'hFFF;
  endfunction

  // One clock of stimulus; when the model expects a pixel edge it queues the result.
  task automatic step(input logic r);
    exp_t e;
    int   nh, nv;
    logic vis;
    @(negedge clk);
    rst      = r;
    vga_data = pat(m_h, m_v);
    if (r) begin
      m_div = 0; m_h = 0; m_v = 0;
    end else begin
      if (m_div == CLK_DIV - 1) begin
        vis = (m_h < HV) && (m_v < VV);
        if (m_h == HT - 1) begin
          nh = 0;
          nv = (m_v == VT - 1) ? 0 : m_v + 1;
        end else begin
          nh = m_h + 1;
          nv = m_v;
        end
        e.edge_n = cyc + 1;
        e.h   = nh;
        e.v   = nv;
        e.rgb = vis ? vga_data : 12'h000;
        e.hs  = !(m_h >= HV + HF && m_h < HV + HF + HS);
        e.vs  = !(m_v >= VV + VF && m_v < VV + VF + VS);
        e.vl  = vis;
        e.ft  = (m_h == HT - 1) && (m_v == VT - 1);
        q.push_back(e);
        m_h = nh;
        m_v = nv;
      end
      m_div = (m_div + 1) % CLK_DIV;
    end
  endtask

  task automatic do_reset(input int n);
    step(1'b1);
    @(posedge clk); #1;
    chk("rst_h_cnt", h_cnt, 0);
    chk("rst_v_cnt", v_cnt, 0);
    chk("rst_hsync", hsync, 1);
    chk("rst_vsync", vsync, 1);
    chk("rst_rgb", {vgaRed, vgaGreen, vgaBlue}, 0);
    chk("rst_pclk_en", pclk_en, 0);
    chk("rst_frame_tick", frame_tick, 0);
    for (int i = 1; i < n; i++) step(1'b1);
  endtask

  int hs_fall0 = -1, hs_fall1 = -1, hs_rise = -1;
  int vs_fall0 = -1, vs_rise = -1;
  int tick_cnt = 0, tick0 = -1, tick1 = -1;

  // Monitor: samples pre-edge strobes mid-cycle, compares pins just after each pixel edge.
  initial begin : monitor
    logic pe, r, vl, ft, started, pend, prev_hs, prev_vs;
    int   last_rst;
    exp_t e;
    started = 1'b0; pend = 1'b0; prev_hs = 1'b1; prev_vs = 1'b1; last_rst = 0;
    forever begin
      @(negedge clk); #1;
      pe = pclk_en; r = rst; vl = valid; ft = frame_tick;
      @(posedge clk); #1;
      if (r === 1'b1) begin
        started  = 1'b1;
        pend     = 1'b1;
        last_rst = cyc;
      end else if (started) begin
        if (ft === 1'b1) begin
          chk("ft_needs_pclk", pe, 1);
          if (meas_en) begin
            tick_cnt++;
            if (tick0 < 0) tick0 = cyc; else if (tick1 < 0) tick1 = cyc;
          end
        end
        if (pe === 1'b1) begin
          if (pend) chk("first_pclk_delay", cyc - last_rst, CLK_DIV);
          pend = 1'b0;
          if (q.size() == 0) begin
            chk("queue_size", q.size(), 1);
          end else begin
            e = q.pop_front();
            chk("pclk_edge", cyc, e.edge_n);
            chk("h_cnt", h_cnt, e.h);
            chk("v_cnt", v_cnt, e.v);
            chk("rgb", {vgaRed, vgaGreen, vgaBlue}, e.rgb);
            chk("hsync", hsync, e.hs);
            chk("vsync", vsync, e.vs);
            chk("valid", vl, e.vl);
            chk("frame_tick", ft, e.ft);
          end
        end
        while (q.size() > 0 && q[0].edge_n < cyc) begin
          chk("missed_pclk_edge", cyc, q[0].edge_n);
          void'(q.pop_front());
        end
        if (meas_en) begin
          if (prev_hs === 1'b1 && hsync === 1'b0) begin
            if (hs_fall0 < 0) begin
              hs_fall0 = cyc;
              chk("hsync_fall_h_cnt", h_cnt, HV + HF + 1);
            end else if (hs_fall1 < 0) begin
              hs_fall1 = cyc;
            end
          end
          if (prev_hs === 1'b0 && hsync === 1'b1 && hs_fall0 >= 0 && hs_rise < 0) hs_rise = cyc;
          if (prev_vs === 1'b1 && vsync === 1'b0 && vs_fall0 < 0) begin
            vs_fall0 = cyc;
            chk("vsync_fall_v_cnt", v_cnt, VV + VF);
            chk("vsync_fall_h_cnt", h_cnt, 1);
          end
          if (prev_vs === 1'b0 && vsync === 1'b1 && vs_fall0 >= 0 && vs_rise < 0) vs_rise = cyc;
        end
      end
      prev_hs = hsync;
      prev_vs = vsync;
    end
  end

  initial begin : stimulus
    do_reset(3);
    // Short reset while colour is on the pins.
    while (!(m_h == 5 && m_v == 3 && m_div == 2)) step(1'b0);
    do_reset(1);
    // Five-clock reset while both syncs are low.
    while (!(m_h == 19 && m_v == 14 && m_div == 1)) step(1'b0);
    do_reset(5);
    meas_en = 1'b1;
    for (int i = 0; i < 2 * FRAME_CLK + 20; i++) step(1'b0);
    @(posedge clk); #2;
    chk("hsync_low_width", hs_rise - hs_fall0, HS * CLK_DIV);
    chk("line_period", hs_fall1 - hs_fall0, HT * CLK_DIV);
    chk("vsync_low_width", vs_rise - vs_fall0, VS * HT * CLK_DIV);
    chk("frame_tick_count", tick_cnt, 2);
    chk("frame_tick_period", tick1 - tick0, FRAME_CLK);
    chk("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
